// File: rtl/mmio_store_queue.sv
// MMIO store queue: buffers CPU stores to the plotter CMD register in an 8-deep FIFO,
// with STATUS/CTRL registers and a pipeline stall when a push hits a full queue.
module mmio_store_queue (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] XM_instruction,
  input  logic [31:0] XM_O,
  input  logic [31:0] data_mem_D,
  input  logic        wren,
  input  logic        cmd_ready,
  output logic        dmem_wren,
  output logic        cmd_valid,
  output logic [31:0] cmd_data,
  output logic [31:0] mmio_rdata,
  output logic        mmio_sel,
  output logic        stall
);

  localparam logic [31:0] ADDR_CMD    = 32'h0000_1000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_1001;
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_1002;
  localparam logic [4:0]  OP_LW       = 5'b01000;

  logic [31:0] mem [8];
  logic [2:0]  wptr, rptr;
  logic [3:0]  count;
  logic        err;

  logic        is_mmio, is_lw, full;
  logic        push_req, ctrl_wr, bad_wr;
  logic        do_push, do_pop, do_flush;
  logic [31:0] status_word;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^XM_instruction[26:0];

  assign is_mmio  = XM_O[12];
  assign is_lw    = (XM_instruction[31:27] == OP_LW);
  assign full     = (count == 4'd8);

  assign push_req = wren & (XM_O == ADDR_CMD);
  assign ctrl_wr  = wren & (XM_O == ADDR_CTRL);
  assign bad_wr   = wren & is_mmio & (XM_O != ADDR_CMD) & (XM_O != ADDR_CTRL);

  // A push into a full queue freezes the front of the pipeline until the consumer drains a slot.
  assign stall    = push_req & full;
  assign do_push  = push_req & ~full;
  assign do_pop   = cmd_valid & cmd_ready;
  assign do_flush = ctrl_wr & data_mem_D[1];

  assign dmem_wren   = wren & ~is_mmio;
  assign cmd_valid   = (count != 4'd0);
  assign cmd_data    = mem[rptr];
  assign status_word = {26'b0, err, full, count};

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wptr] <= data_mem_D;
    end
  end

  // Flush beats a same-cycle pop; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= 3'd0;
      rptr  <= 3'd0;
      count <= 4'd0;
    end else if (do_flush) begin
      wptr  <= 3'd0;
      rptr  <= 3'd0;
      count <= 4'd0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 3'd1;
      end
      if (do_pop) begin
        rptr <= rptr + 3'd1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error: setting on a bad store wins over a clear request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (bad_wr) begin
      err <= 1'b1;
    end else if (ctrl_wr & data_mem_D[0]) begin
      err <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mmio_sel   <= 1'b0;
      mmio_rdata <= 32'd0;
    end else if (!stall) begin
      mmio_sel   <= is_lw & is_mmio;
      mmio_rdata <= (XM_O == ADDR_STATUS) ? status_word : 32'd0;
    end
  end

endmodule

// File: tb/tb_mmio_store_queue.sv
// Self-checking bench for mmio_store_queue: a queue of expected words is filled on
// accepted pushes and drained as the consumer pops, alongside a count/err model.
module tb_mmio_store_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] XM_instruction, XM_O, data_mem_D;
  logic        wren, cmd_ready;
  logic        dmem_wren, cmd_valid, mmio_sel, stall;
  logic [31:0] cmd_data, mmio_rdata;

  localparam logic [31:0] LW = 32'h4000_0000;
  localparam logic [31:0] SW = 32'h3800_0000;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  logic        err_m  = 1'b0;
  logic [31:0] exp_w;
  logic [31:0] word;

  mmio_store_queue dut (
    .clock(clock), .reset(reset), .XM_instruction(XM_instruction), .XM_O(XM_O),
    .data_mem_D(data_mem_D), .wren(wren), .cmd_ready(cmd_ready), .dmem_wren(dmem_wren),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .mmio_rdata(mmio_rdata),
    .mmio_sel(mmio_sel), .stall(stall)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [31:0] instr, input logic [31:0] addr,
                       input logic [31:0] data, input logic wr, input logic rdy);
    XM_instruction = instr;
    XM_O           = addr;
    data_mem_D     = data;
    wren           = wr;
    cmd_ready      = rdy;
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issues an lw to STATUS and leaves the registered result ready to sample.
  task automatic read_status();
    drive(LW, 32'h1001, 32'd0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    drive(SW, 32'h1000, w, 1'b1, 1'b0);
    exp_q.push_back(w);
    tick();
  endtask

  function automatic logic [31:0] status_model();
    int n;
    n = exp_q.size();
    return {26'b0, err_m, (n == 8), 4'(n)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    idle();
    #12;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", cmd_valid); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
    n_cmp++; if (mmio_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sel: got %b want 0", mmio_sel); end
    n_cmp++; if (mmio_rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 0", mmio_rdata); end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_push_pop();
    drive(SW, 32'h1000, 32'hA5, 1'b1, 1'b0);
    #1;
    n_cmp++; if (dmem_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_dmem_wren: got %b want 0", dmem_wren); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_stall: got %b want 0", stall); end
    exp_q.push_back(32'hA5);
    tick();
    idle();
    #1;
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_valid: got %b want 1", cmd_valid); end
    n_cmp++; if (cmd_data !== exp_q[0]) begin n_fail++; $display("[TB] FAIL basic_data: got %h want %h", cmd_data, exp_q[0]); end
    read_status();
    n_cmp++; if (mmio_sel !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_sel: got %b want 1", mmio_sel); end
    n_cmp++; if (mmio_rdata !== status_model()) begin n_fail++; $display("[TB] FAIL basic_count: got %h want %h", mmio_rdata, status_model()); end
    cmd_ready = 1'b1;
    #1;
    exp_w = exp_q.pop_front();
    n_cmp++; if (cmd_data !== exp_w) begin n_fail++; $display("[TB] FAIL basic_pop: got %h want %h", cmd_data, exp_w); end
    tick();
    cmd_ready = 1'b0;
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_empty: got %b want 0", cmd_valid); end
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 8; i++) push_word($urandom);
    read_status();
    n_cmp++; if (mmio_rdata !== 32'h18) begin n_fail++; $display("[TB] FAIL full_status: got %h want 00000018", mmio_rdata); end
    word = $urandom;
    drive(SW, 32'h1000, word, 1'b1, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL full_stall: got %b want 1", stall); end
    tick();
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL full_stall_hold: got %b want 1", stall); end
    n_cmp++; if (mmio_sel !== 1'b1 || mmio_rdata !== 32'h18) begin n_fail++; $display("[TB] FAIL full_mmio_hold: got sel=%b rdata=%h want sel=1 rdata=00000018", mmio_sel, mmio_rdata); end
    n_cmp++; if (cmd_data !== exp_q[0]) begin n_fail++; $display("[TB] FAIL full_head: got %h want %h", cmd_data, exp_q[0]); end
    cmd_ready = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL full_stall_ready: got %b want 1", stall); end
    exp_w = exp_q.pop_front();
    n_cmp++; if (cmd_data !== exp_w) begin n_fail++; $display("[TB] FAIL full_pop: got %h want %h", cmd_data, exp_w); end
    tick();
    cmd_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL full_release: got %b want 0", stall); end
    exp_q.push_back(word);
    tick();
    idle();
    #1;
    n_cmp++; if (mmio_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL full_sel_after: got %b want 0", mmio_sel); end
    read_status();
    n_cmp++; if (mmio_rdata !== status_model()) begin n_fail++; $display("[TB] FAIL full_refill: got %h want %h", mmio_rdata, status_model()); end
    for (int i = 0; i < 8; i++) begin
      cmd_ready = 1'b1;
      #1;
      exp_w = exp_q.pop_front();
      n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== exp_w) begin n_fail++; $display("[TB] FAIL full_drain%0d: got v=%b %h want v=1 %h", i, cmd_valid, cmd_data, exp_w); end
      tick();
    end
    cmd_ready = 1'b0;
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL full_empty: got %b want 0", cmd_valid); end
  endtask

  task automatic test_push_pop_same_cycle();
    for (int i = 0; i < 3; i++) push_word($urandom);
    word = $urandom;
    drive(SW, 32'h1000, word, 1'b1, 1'b1);
    #1;
    exp_w = exp_q.pop_front();
    n_cmp++; if (cmd_data !== exp_w) begin n_fail++; $display("[TB] FAIL simul_pop: got %h want %h", cmd_data, exp_w); end
    exp_q.push_back(word);
    tick();
    idle();
    #1;
    n_cmp++; if (cmd_data !== exp_q[0]) begin n_fail++; $display("[TB] FAIL simul_head: got %h want %h", cmd_data, exp_q[0]); end
    read_status();
    n_cmp++; if (mmio_rdata !== 32'h3) begin n_fail++; $display("[TB] FAIL simul_count: got %h want 00000003", mmio_rdata); end
    for (int i = 0; i < 3; i++) begin
      cmd_ready = 1'b1;
      #1;
      exp_w = exp_q.pop_front();
      n_cmp++; if (cmd_data !== exp_w) begin n_fail++; $display("[TB] FAIL simul_drain%0d: got %h want %h", i, cmd_data, exp_w); end
      tick();
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_err_flush();
    for (int i = 0; i < 8; i++) push_word($urandom);
    drive(SW, 32'h1005, 32'hFF, 1'b1, 1'b0);
    #1;
    n_cmp++; if (dmem_wren !== 1'b0) begin n_fail++; $display("[TB] FAIL err_dmem_wren: got %b want 0", dmem_wren); end
    err_m = 1'b1;
    tick();
    read_status();
    n_cmp++; if (mmio_sel !== 1'b1 || mmio_rdata !== 32'h38) begin n_fail++; $display("[TB] FAIL err_status: got sel=%b %h want sel=1 00000038", mmio_sel, mmio_rdata); end
    drive(SW, 32'h1002, 32'h1, 1'b1, 1'b0);
    err_m = 1'b0;
    tick();
    read_status();
    n_cmp++; if (mmio_rdata !== status_model()) begin n_fail++; $display("[TB] FAIL err_clear: got %h want %h", mmio_rdata, status_model()); end
    drive(SW, 32'h1005, 32'h0, 1'b1, 1'b0);
    err_m = 1'b1;
    tick();
    drive(SW, 32'h1002, 32'h3, 1'b1, 1'b1);
    err_m = 1'b0;
    exp_q.delete();
    tick();
    idle();
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_valid: got %b want 0", cmd_valid); end
    read_status();
    n_cmp++; if (mmio_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL flush_status: got %h want 00000000", mmio_rdata); end
    drive(SW, 32'h1005, 32'h0, 1'b0, 1'b0);
    tick();
    drive(LW, 32'h1000, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    n_cmp++; if (mmio_sel !== 1'b1 || mmio_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL lw_cmd: got sel=%b %h want sel=1 00000000", mmio_sel, mmio_rdata); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_no_push: got %b want 0", cmd_valid); end
    read_status();
    n_cmp++; if (mmio_rdata !== status_model()) begin n_fail++; $display("[TB] FAIL noop_err: got %h want %h", mmio_rdata, status_model()); end
  endtask

  task automatic test_dmem_and_reset();
    push_word($urandom);
    drive(SW, 32'h0040, 32'hDEAD, 1'b1, 1'b0);
    #1;
    n_cmp++; if (dmem_wren !== 1'b1) begin n_fail++; $display("[TB] FAIL dmem_wren: got %b want 1", dmem_wren); end
    tick();
    drive(LW, 32'h0040, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    n_cmp++; if (mmio_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL dmem_sel: got %b want 0", mmio_sel); end
    n_cmp++; if (cmd_data !== exp_q[0]) begin n_fail++; $display("[TB] FAIL dmem_queue: got %h want %h", cmd_data, exp_q[0]); end
    for (int i = 0; i < 4; i++) push_word($urandom);
    read_status();
    n_cmp++; if (mmio_sel !== 1'b1 || mmio_rdata !== 32'h5) begin n_fail++; $display("[TB] FAIL pre_reset: got sel=%b %h want sel=1 00000005", mmio_sel, mmio_rdata); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (cmd_valid !== 1'b0 || mmio_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset: got valid=%b sel=%b want 0 0", cmd_valid, mmio_sel); end
    exp_q.delete();
    err_m = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    tick();
    push_word(32'h1234_5678);
    idle();
    cmd_ready = 1'b1;
    #1;
    exp_w = exp_q.pop_front();
    n_cmp++; if (cmd_valid !== 1'b1 || cmd_data !== exp_w) begin n_fail++; $display("[TB] FAIL resume: got v=%b %h want v=1 %h", cmd_valid, cmd_data, exp_w); end
    tick();
    cmd_ready = 1'b0;
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL resume_empty: got %b want 0", cmd_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_push_pop();
    test_full_stall();
    test_push_pop_same_cycle();
    test_err_flush();
    test_dmem_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_store_queue.md
MMIO_STORE_QUEUE -- requirements
Module: mmio_store_queue

Interface
REQ-001 SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port XM_instruction, input, 32, XM-stage instruction; opcode [31:27], where lw = 01000 and sw = 00111.
REQ-004 SHALL have port XM_O, input, 32, XM-stage ALU result used as the word address.
REQ-005 SHALL have port data_mem_D, input, 32, store data after MW bypass.
REQ-006 SHALL have port wren, input, 1, raw store enable.
REQ-007 SHALL have port cmd_ready, input, 1, plotter consumer accepts the head word this cycle.
REQ-008 SHALL have port dmem_wren, output, 1, write enable to data memory.
REQ-009 SHALL have port cmd_valid, output, 1, queue non-empty.
REQ-010 SHALL have port cmd_data, output, 32, queue head word.
REQ-011 SHALL have port mmio_rdata, output, 32, registered MMIO load data, aligned with the MW stage.
REQ-012 SHALL have port mmio_sel, output, 1, registered; MW stage selects mmio_rdata over the data memory q.
REQ-013 SHALL have port stall, output, 1, freezes PC, FD, DX and XM this cycle.

Function
REQ-014 SHALL decode an MMIO access when XM_O[12]=1; otherwise the access is to data memory.
REQ-015 SHALL assign the MMIO registers as follows: CMD 0x1000 (write pushes), STATUS 0x1001 (read), CTRL 0x1002 (write).
REQ-016 SHALL drive dmem_wren = wren & ~XM_O[12], combinationally.
REQ-017 SHALL implement an 8-entry x 32-bit circular FIFO with 3-bit read/write pointers that wrap 7->0 and a 4-bit count ranging 0..8.
REQ-018 SHALL define a push request as wren & address==0x1000; when count<8 the request writes data_mem_D at wptr, and wptr and count advance at the clock edge.
REQ-019 SHALL drive stall=1 combinationally when a push request occurs with registered count==8, with no push and no state change; stall SHALL NOT depend on cmd_ready.
REQ-020 SHALL perform a pop when cmd_valid & cmd_ready; rptr advances and count decrements.
REQ-021 SHALL leave count unchanged and advance both pointers when a push and a pop occur in the same cycle.
REQ-022 SHALL drive cmd_valid = (count!=0) and cmd_data = mem[rptr], both combinationally from registered state.
REQ-023 SHALL implement a CTRL write (wren & address==0x1002) as follows: data_mem_D[0]=1 clears err; data_mem_D[1]=1 flushes, setting pointers and count to 0.
REQ-024 SHALL give flush priority over a same-cycle pop.
REQ-025 SHALL set the sticky err bit on an MMIO store to any address other than 0x1000 or 0x1002; the store is otherwise ignored.
REQ-026 SHALL set err when a CTRL write has data_mem_D[0]=1 and also addresses an invalid case in the same cycle; set wins (not reachable with a single address).
REQ-027 SHALL register, at each edge when stall=0, mmio_sel <= (opcode==lw & XM_O[12]).
REQ-028 SHALL register, at each edge when stall=0, mmio_rdata <= {26'b0, err, count==8, count[3:0]} for STATUS and 0 for other MMIO addresses, giving one-cycle latency.
REQ-029 SHALL hold mmio_sel and mmio_rdata while stall=1.
REQ-030 SHALL NOT let an lw to MMIO modify the FIFO or err.
REQ-031 SHALL ignore a sw to MMIO with wren=0.

Reset
REQ-032 SHALL, while reset=1 (asynchronous, active-high), clear the pointers, count, err, mmio_rdata and mmio_sel to 0 immediately.
REQ-033 SHALL hold cmd_valid=0 and stall=0 while reset=1.
REQ-034 SHALL discard queue contents on reset mid-operation; FIFO memory need not be cleared.
REQ-035 SHALL resume normal operation at the first rising edge after reset deasserts.

Verification
REQ-036 SHALL cover basic push/pop: sw 0xA5 to 0x1000 with cmd_ready=0 -> next cycle cmd_valid=1, cmd_data=0xA5, count=1; then assert cmd_ready for one cycle -> cmd_valid=0.
REQ-037 SHALL cover full stall: push 8 words with cmd_ready=0, then a 9th push -> stall=1 and count stays 8; assert cmd_ready -> next cycle stall=0 and the 9th word is enqueued; output order matches push order across the pointer wrap.
REQ-038 SHALL cover simultaneous push and pop at count=3 -> count stays 3 and the head advances.
REQ-039 SHALL cover a STATUS read: lw 0x1001 with count=8, err=1 -> one cycle later mmio_sel=1, mmio_rdata=0x38.
REQ-040 SHALL cover error handling and flush: sw to 0x1005 -> err=1, dmem_wren=0; sw 0x3 to 0x1002 -> err=0, count=0, cmd_valid=0.
REQ-041 SHALL cover data memory pass-through and reset: sw to 0x0040 -> dmem_wren=1 and the queue unaffected; assert reset asynchronously with count=5 -> cmd_valid=0 and mmio_sel=0 before the next edge.
